// File: rtl/fp8_div.sv
// fp8_div: sequential FP8 divider using a restoring, one-bit-per-cycle mantissa divider.
// Build option: define FP8_DIV_EARLY_EXIT_EN to let special operands skip the divide loop.
module fp8_div (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic [4:0] flags,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for operands, in_ready high
  // DIVIDE | one quotient bit per cycle, 8 cycles
  // ROUND  | normalise, round, register result and flags
  // DONE   | out_valid high until the consumer accepts
  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} stateT;

  stateT state, stateNext;

  logic [7:0] aReg, bReg;
  logic [5:0] rem;
  logic [7:0] quot;
  logic [2:0] cnt;

  logic aZero, bZero, aInf, bInf, aNaN, bNaN, sign;

  assign sign  = aReg[7] ^ bReg[7];
  assign aZero = (aReg[6:4] == 3'd0);
  assign bZero = (bReg[6:4] == 3'd0);
  assign aInf  = (aReg[6:4] == 3'd7) && (aReg[3:0] == 4'd0);
  assign bInf  = (bReg[6:4] == 3'd7) && (bReg[3:0] == 4'd0);
  assign aNaN  = (aReg[6:4] == 3'd7) && (aReg[3:0] != 4'd0);
  assign bNaN  = (bReg[6:4] == 3'd7) && (bReg[3:0] != 4'd0);

  logic       special;
  logic [7:0] specResult;
  logic [4:0] specFlags;

  // Special operands, highest priority first.
  always_comb begin
    special    = 1'b1;
    specResult = 8'h00;
    specFlags  = 5'b00000;
    if (aNaN || bNaN || (aZero && bZero) || (aInf && bInf)) begin
      specResult = 8'h78;
      specFlags  = 5'b10000;
    end else if (bZero && !aInf) begin
      specResult = {sign, 7'h70};
      specFlags  = 5'b01000;
    end else if (aInf) begin
      specResult = {sign, 7'h70};
    end else if (aZero || bInf) begin
      specResult = {sign, 7'h00};
    end else begin
      special = 1'b0;
    end
  end

  logic earlyExit;
`ifdef FP8_DIV_EARLY_EXIT_EN
  assign earlyExit = special && (cnt == 3'd0);
`else
  assign earlyExit = 1'b0;
`endif

  logic [5:0] divisor;
  logic       geq;
  logic [5:0] remSub;
  logic [5:0] remNext;

  assign divisor = {2'b01, bReg[3:0]};
  assign geq     = (rem >= divisor);
  assign remSub  = geq ? (rem - divisor) : rem;
  // remSub is always below the divisor (< 32), so the shift never loses a bit.
  assign remNext = {remSub[4:0], 1'b0};

  logic signed [4:0] expRaw, expNorm, expRnd;
  logic [3:0] frac;
  logic       guardBit, roundBit, stickyBit, roundUp, inexact;
  logic [4:0] fracRnd;
  logic [7:0] normResult;
  logic [4:0] normFlags;

  assign expRaw = $signed({2'b00, aReg[6:4]}) - $signed({2'b00, bReg[6:4]}) + 5'sd3;

  always_comb begin
    frac       = quot[6:3];
    guardBit   = quot[2];
    roundBit   = quot[1];
    stickyBit  = quot[0] | (|rem);
    expNorm    = expRaw;
    normResult = 8'h00;
    normFlags  = 5'b00000;
    if (!quot[7]) begin
      frac      = quot[5:2];
      guardBit  = quot[1];
      roundBit  = quot[0];
      stickyBit = |rem;
      expNorm   = expRaw - 5'sd1;
    end
    roundUp = guardBit && (roundBit || stickyBit || frac[0]);
    fracRnd = {1'b0, frac} + {4'd0, roundUp};
    expRnd  = fracRnd[4] ? (expNorm + 5'sd1) : expNorm;
    inexact = guardBit | roundBit | stickyBit;
    if (expRnd >= 5'sd7) begin
      normResult = {sign, 7'h70};
      normFlags  = 5'b00101;
    end else if (expRnd <= 5'sd0) begin
      normResult = {sign, 7'h00};
      normFlags  = 5'b00011;
    end else begin
      normResult = {sign, expRnd[2:0], fracRnd[3:0]};
      normFlags  = {4'b0000, inexact};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:   if (in_valid) stateNext = DIVIDE;
      DIVIDE: begin
        if (earlyExit) begin
          stateNext = DONE;
        end else if (cnt == 3'd7) begin
          stateNext = ROUND;
        end
      end
      ROUND:  stateNext = DONE;
      DONE:   if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aReg   <= 8'h00;
      bReg   <= 8'h00;
      rem    <= 6'd0;
      quot   <= 8'h00;
      cnt    <= 3'd0;
      result <= 8'h00;
      flags  <= 5'b00000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aReg <= a;
            bReg <= b;
            rem  <= {2'b01, a[3:0]};
            quot <= 8'h00;
            cnt  <= 3'd0;
          end
        end
        DIVIDE: begin
          rem  <= remNext;
          quot <= {quot[6:0], geq};
          cnt  <= cnt + 3'd1;
          if (earlyExit) begin
            cnt    <= 3'd0;
            result <= specResult;
            flags  <= specFlags;
          end
        end
        ROUND: begin
          result <= special ? specResult : normResult;
          flags  <= special ? specFlags : normFlags;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp8_div.sv
// tb_fp8_div: directed scoreboard bench for fp8_div (both FP8_DIV_EARLY_EXIT_EN builds).
module tb_fp8_div;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       in_ready, out_valid, busy;
  logic [7:0] result;
  logic [4:0] flags;

  int passCnt = 0;
  int totalCnt = 0;

  typedef struct {
    logic [7:0] res;
    logic [4:0] flg;
    int         lat;
  } expT;

  expT sbq[$];

`ifdef FP8_DIV_EARLY_EXIT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 9;
`endif
  localparam int NORM_LAT = 9;

  always #5 clk = ~clk;

  fp8_div dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .flags(flags),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [7:0] er, input logic [4:0] ef, input int el);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    sbq.push_back('{er, ef, el});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    int  lat = 0;
    expT e;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " out_valid"}, out_valid, 1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
    end else begin
      e = '{8'hxx, 5'hxx, -1};
    end
    check({tag, " result"}, result, e.res);
    check({tag, " flags"}, flags, e.flg);
    check({tag, " latency"}, lat, e.lat);
    repeat (hold) begin
      @(negedge clk);
      check({tag, " held result"}, result, e.res);
      check({tag, " held flags"}, flags, e.flg);
      check({tag, " held out_valid"}, out_valid, 1);
      check({tag, " held in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post out_valid"}, out_valid, 0);
    check({tag, " post in_ready"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset result", result, 8'h00);
    check("reset flags", flags, 5'h00);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    issue("6/2", 8'h58, 8'h40, 8'h48, 5'h00, NORM_LAT);     collect("6/2", 0);
    issue("1/3", 8'h30, 8'h48, 8'h15, 5'h01, NORM_LAT);     collect("1/3", 0);
    issue("1/0", 8'h30, 8'h00, 8'h70, 5'h08, SPEC_LAT);     collect("1/0", 0);
    issue("0/0", 8'h00, 8'h00, 8'h78, 5'h10, SPEC_LAT);     collect("0/0", 0);
    issue("ovf", 8'h6F, 8'h10, 8'h70, 5'h05, NORM_LAT);     collect("ovf", 0);
    issue("unf", 8'h10, 8'h6F, 8'h00, 5'h03, NORM_LAT);     collect("unf", 0);
    issue("rndup", 8'h30, 8'h3F, 8'h21, 5'h01, NORM_LAT);   collect("rndup", 0);
    issue("neg", 8'hB0, 8'h30, 8'hB0, 5'h00, NORM_LAT);     collect("neg", 0);
    issue("neg/0", 8'hB0, 8'h00, 8'hF0, 5'h08, SPEC_LAT);   collect("neg/0", 0);
    issue("inf/inf", 8'h70, 8'h70, 8'h78, 5'h10, SPEC_LAT); collect("inf/inf", 0);
    issue("nan", 8'h79, 8'h30, 8'h78, 5'h10, SPEC_LAT);     collect("nan", 0);
    issue("inf/0", 8'h70, 8'h00, 8'h70, 5'h00, SPEC_LAT);   collect("inf/0", 0);
    issue("-inf/1", 8'hF0, 8'h30, 8'hF0, 5'h00, SPEC_LAT);  collect("-inf/1", 0);
    issue("0/-1", 8'h00, 8'hB0, 8'h80, 5'h00, SPEC_LAT);    collect("0/-1", 0);
    issue("1/-inf", 8'h30, 8'hF0, 8'h80, 5'h00, SPEC_LAT);  collect("1/-inf", 0);
    issue("e0", 8'h10, 8'h40, 8'h00, 5'h03, NORM_LAT);      collect("e0", 0);
    issue("e1", 8'h10, 8'h30, 8'h10, 5'h00, NORM_LAT);      collect("e1", 0);
    issue("e6", 8'h60, 8'h30, 8'h60, 5'h00, NORM_LAT);      collect("e6", 0);
    issue("e7", 8'h60, 8'h20, 8'h70, 5'h05, NORM_LAT);      collect("e7", 0);

    // Second pair presented while busy; it must wait for the output handshake.
    issue("b2b1", 8'h58, 8'h40, 8'h48, 5'h00, NORM_LAT);
    a = 8'h30;
    b = 8'h48;
    in_valid = 1'b1;
    sbq.push_back('{8'h15, 5'h01, NORM_LAT});
    collect("b2b1", 5);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b2 busy", busy, 1);
    collect("b2b2", 0);

    // Reset pulse in the middle of DIVIDE discards the operation.
    issue("abort", 8'h58, 8'h40, 8'h48, 5'h00, NORM_LAT);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", out_valid, 0);
    check("abort result", result, 8'h00);
    check("abort flags", flags, 5'h00);
    check("abort busy", busy, 0);
    check("abort in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    check("abort no out_valid", seen, 0);

    issue("recover", 8'h30, 8'h48, 8'h15, 5'h01, NORM_LAT); collect("recover", 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passCnt, totalCnt);
    $fatal(1, "watchdog expired");
  end

endmodule
